// File: rtl/pixel_pkg.sv
// Shared types and frame geometry for the pixel word packer.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package pixel_pkg;

  localparam int PIX_WIDTH     = 8;
  localparam int PIX_PER_WORD  = 4;
  localparam int FRAME_WIDTH   = 240;
  localparam int FRAME_HEIGHT  = 240;
  localparam int FIFO_DEPTH    = 4;
  localparam int ADDR_WIDTH    = 16;

  localparam int WORD_BITS     = PIX_WIDTH * PIX_PER_WORD;
  localparam int WORDS_PER_ROW = FRAME_WIDTH / PIX_PER_WORD;
  localparam int LANE_BITS     = $clog2(PIX_PER_WORD);

  // One packed output word as it travels through the FIFO.
  typedef struct packed {
    logic [WORD_BITS-1:0]  data;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  sof;
    logic                  eof;
  } word_t;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    PACK     = 2'd1,
    DROP     = 2'd2
  } state_t;

  // Linear word address of the word holding pixel (row, col), truncated.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [15:0] row,
                                                      input logic [15:0] col);
    logic [31:0] w_lin;
    w_lin = 32'(row) * 32'(WORDS_PER_ROW) + 32'(col >> LANE_BITS);
    return w_lin[ADDR_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO; head entry is visible whenever o_head_vld is high.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: push is dropped when full unless a pop happens the same cycle.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push_vld,
  input  logic [WIDTH-1:0] i_push_dat,
  output logic             o_full,
  output logic             o_head_vld,
  input  logic             i_pop_rdy,
  output logic [WIDTH-1:0] o_head_dat
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign o_head_vld = (r_count != '0);
  assign o_full     = (r_count == (PW+1)'(DEPTH));
  assign w_pop      = o_head_vld && i_pop_rdy;
  // A pop frees the slot on the same edge, so a push into a full FIFO is fine then.
  assign w_push     = i_push_vld && (!o_full || w_pop);
  assign o_head_dat = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties without touching storage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Storage is reset so the head reads as zero straight out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

endmodule

// File: rtl/pixel_word_packer.sv
// Packs PIX_PER_WORD trimmed pixels into address-tagged words with SOF/EOF flags.
// Latency: out_valid_o rises the cycle after the edge that sampled the completing pixel.
// Backpressure: 4-deep output FIFO; a word meeting a full FIFO drops the rest of the frame.
module pixel_word_packer #(
  // Geometry and widths live in pixel_pkg (word_t and word_addr are sized there);
  // these parameters default to the package values and must stay equal to them.
  parameter int PIX_WIDTH    = pixel_pkg::PIX_WIDTH,
  parameter int PIX_PER_WORD = pixel_pkg::PIX_PER_WORD,
  parameter int FRAME_WIDTH  = pixel_pkg::FRAME_WIDTH,
  parameter int FRAME_HEIGHT = pixel_pkg::FRAME_HEIGHT,
  parameter int FIFO_DEPTH   = pixel_pkg::FIFO_DEPTH,
  parameter int ADDR_WIDTH   = pixel_pkg::ADDR_WIDTH
) (
  input  logic                              pixclk_i,
  input  logic                              rst_ni,
  input  logic                              pix_valid_i,
  input  logic [PIX_WIDTH-1:0]              pix_i,
  input  logic [15:0]                       row_i,
  input  logic [15:0]                       col_i,
  input  logic                              frame_rst_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [PIX_WIDTH*PIX_PER_WORD-1:0] out_data_o,
  output logic [ADDR_WIDTH-1:0]             out_addr_o,
  output logic                              out_sof_o,
  output logic                              out_eof_o,
  output logic                              overflow_o,
  input  logic                              clear_i,
  output logic [7:0]                        drop_count_o
);

  import pixel_pkg::*;

  localparam int              WB        = PIX_WIDTH * PIX_PER_WORD;
  localparam int              LW        = $clog2(PIX_PER_WORD);
  localparam logic [LW-1:0]   LAST_LANE = LW'(PIX_PER_WORD - 1);

  state_t                  r_state;
  logic [WB-1:0]           r_data;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_sof;
  logic                    r_have;
  logic [LW-1:0]           r_next_lane;
  logic                    r_overflow;
  logic [7:0]              r_drop_cnt;

  logic [LW-1:0]           w_lane;
  logic                    w_is_sof;
  logic                    w_is_eof;
  logic [WB-1:0]           w_in_data;
  logic [WB-1:0]           w_lane0_dat;
  logic                    w_complete;
  logic                    w_full;
  logic                    w_head_vld;
  logic                    w_pop;
  logic                    w_ovf;
  word_t                   w_push_word;
  word_t                   w_head;

  assign w_lane      = col_i[LW-1:0];
  assign w_is_sof    = (row_i == 16'd0) && (col_i == 16'd0);
  assign w_is_eof    = (row_i == 16'(FRAME_HEIGHT - 1)) && (col_i == 16'(FRAME_WIDTH - 1));
  assign w_lane0_dat = WB'(pix_i);

  // Partial word with the current pixel dropped into its lane.
  always_comb begin
    w_in_data = r_data;
    w_in_data[w_lane*PIX_WIDTH +: PIX_WIDTH] = pix_i;
  end

  // The in-order last-lane pixel of a word being built completes it; a mid-frame
  // SOF never completes a word because it restarts the frame instead.
  assign w_complete = !frame_rst_i && pix_valid_i && (r_state == PACK) && !w_is_sof &&
                      r_have && (w_lane == r_next_lane) && (w_lane == LAST_LANE);
  assign w_pop      = w_head_vld && out_ready_i;
  assign w_ovf      = w_complete && w_full && !w_pop;

  assign w_push_word.data = w_in_data;
  assign w_push_word.addr = r_addr;
  assign w_push_word.sof  = r_sof;
  assign w_push_word.eof  = w_is_eof;

  // Frame state and partial-word accumulation.
  always_ff @(posedge pixclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= WAIT_SOF;
      r_data      <= '0;
      r_addr      <= '0;
      r_sof       <= 1'b0;
      r_have      <= 1'b0;
      r_next_lane <= '0;
    end else if (frame_rst_i) begin
      r_state <= WAIT_SOF;
      r_have  <= 1'b0;
    end else if (pix_valid_i) begin
      case (r_state)
        WAIT_SOF, DROP: begin
          if (w_is_sof) begin
            r_state     <= PACK;
            r_data      <= w_lane0_dat;
            r_addr      <= '0;
            r_sof       <= 1'b1;
            r_have      <= 1'b1;
            r_next_lane <= LW'(1);
          end
        end
        PACK: begin
          if (w_is_sof) begin
            r_data      <= w_lane0_dat;
            r_addr      <= '0;
            r_sof       <= 1'b1;
            r_have      <= 1'b1;
            r_next_lane <= LW'(1);
          end else if (r_have && (w_lane == r_next_lane)) begin
            if (w_lane == LAST_LANE) begin
              r_have <= 1'b0;
              if (w_ovf)         r_state <= DROP;
              else if (w_is_eof) r_state <= WAIT_SOF;
            end else begin
              r_data      <= w_in_data;
              r_next_lane <= r_next_lane + 1'b1;
            end
          end else if (w_lane == '0) begin
            // Out-of-order lane 0: abandon the partial word and start afresh.
            r_data      <= w_lane0_dat;
            r_addr      <= word_addr(row_i, col_i);
            r_sof       <= 1'b0;
            r_have      <= 1'b1;
            r_next_lane <= LW'(1);
          end else begin
            // Out-of-order non-zero lane: wait silently for the next lane 0.
            r_have <= 1'b0;
          end
        end
        default: r_state <= WAIT_SOF;
      endcase
    end
  end

  // Sticky overflow flag and saturating drop counter; an overflow beats clear.
  always_ff @(posedge pixclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_ovf) begin
      r_overflow <= 1'b1;
      if (clear_i)                 r_drop_cnt <= 8'd1;
      else if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end else if (clear_i) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(word_t))
  ) u_fifo (
    .i_clk      (pixclk_i),
    .i_rst_n    (rst_ni),
    .i_flush    (frame_rst_i),
    .i_push_vld (w_complete),
    .i_push_dat (w_push_word),
    .o_full     (w_full),
    .o_head_vld (w_head_vld),
    .i_pop_rdy  (out_ready_i),
    .o_head_dat (w_head)
  );

  assign out_valid_o  = w_head_vld;
  assign out_data_o   = w_head.data;
  assign out_addr_o   = w_head.addr;
  assign out_sof_o    = w_head.sof;
  assign out_eof_o    = w_head.eof;
  assign overflow_o   = r_overflow;
  assign drop_count_o = r_drop_cnt;

endmodule
